// File: rtl/pll_reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer_pkg
// Shared types and constants for the PLL reset sequencer:
//   state_e  - sequencer states
//   RETRY_W  - width of the retry_count output
//   LOSS_W   - width of the lock_loss_count output
//   max3()   - helper used to size the shared phase counter
// -----------------------------------------------------------------------------
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_e;

    localparam int RETRY_W = 2;
    localparam int LOSS_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears both flops
//   d_i    - asynchronous input
//   q_o    - synchronized output (two clk_i cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source and the chain stays two deep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Drives a PLL reset pulse, waits for lock with a timeout and bounded retries,
// demands a stable lock window, then releases the downstream system reset.
// A lock loss while running restarts the whole sequence.
//   clk             - free-running reference clock
//   reset_n         - asynchronous active-low reset
//   pll_locked      - PLL lock indication, asynchronous to clk
//   restart         - single-cycle request to restart the sequence
//   pll_rst         - active-high reset to the PLL (RESET and FAIL only)
//   sys_reset_n     - active-low reset for PLL-clocked logic (high in RUN only)
//   lock_fail       - sticky: retries exhausted
//   retry_count     - failed lock attempts in the current sequence
//   lock_loss_count - lock losses seen while running, saturating
// -----------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 20,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_reset_n,
    output logic               lock_fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [LOSS_W-1:0]  lock_loss_count
);

    // One counter serves every timed phase, so it is sized for the longest.
    localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_MAX  = '1;

    logic               locked_sync;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               fail_q, fail_d;
    logic               pll_rst_q;
    logic               sys_rst_n_q;

    sync_2ff u_lock_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (locked_sync)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        fail_d  = fail_q;

        if (restart) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = '0;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout. The detecting cycle
                    // is the first cycle of the stable window.
                    if (locked_sync) begin
                        cnt_d = CNT_W'(1);
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_d = ST_RUN;
                            retry_d = '0;
                        end else begin
                            state_d = ST_STABLE;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d   = '0;
                        retry_d = retry_q + RETRY_W'(1);
                        if (retry_q + RETRY_W'(1) == RETRY_MAX) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = ST_RESET;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!locked_sync) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!locked_sync) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                        if (loss_q != LOSS_MAX) loss_d = loss_q + LOSS_W'(1);
                    end
                end
                ST_FAIL: ;
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output flops are loaded from the next state so they switch on the same
    // edge as the state register itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            fail_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            fail_q      <= fail_d;
            pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset_n     = sys_rst_n_q;
    assign lock_fail       = fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Bench for pll_reset_sequencer (RST_PULSE=4, TIMEOUT=32, STABLE=8,
// MAX_RETRIES=2). A cycle model of the sequencing rules runs alongside the DUT
// and is compared on every falling edge; directed scenarios pin measured
// latencies and counts to hand-computed numbers, then a random phase follows.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int RP = 4;
    localparam int TO = 32;
    localparam int ST = 8;
    localparam int MR = 2;

    localparam int PULSE  = 0;
    localparam int WAIT   = 1;
    localparam int SETTLE = 2;
    localparam int RUN    = 3;
    localparam int DEAD   = 4;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart    = 1'b0;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       lock_fail;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .restart         (restart),
        .pll_rst         (pll_rst),
        .sys_reset_n     (sys_reset_n),
        .lock_fail       (lock_fail),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode, m_elapsed, m_streak, m_retries, m_losses;
    bit m_failed, pipe0, pipe1;

    task automatic model_reset();
        m_mode = PULSE; m_elapsed = 0; m_streak = 0;
        m_retries = 0; m_losses = 0; m_failed = 0;
        pipe0 = 0; pipe1 = 0;
    endtask

    task automatic model_step(input bit seen);
        if (restart) begin
            m_mode = PULSE; m_elapsed = 0; m_retries = 0; m_failed = 0;
        end else begin
            case (m_mode)
                PULSE: begin
                    m_elapsed++;
                    if (m_elapsed == RP) begin m_mode = WAIT; m_elapsed = 0; end
                end
                WAIT: begin
                    m_elapsed++;
                    if (seen) begin
                        m_streak = 1;
                        if (m_streak >= ST) begin m_mode = RUN; m_retries = 0; end
                        else m_mode = SETTLE;
                    end else if (m_elapsed == TO) begin
                        m_retries++;
                        m_elapsed = 0;
                        if (m_retries == MR) begin m_mode = DEAD; m_failed = 1; end
                        else m_mode = PULSE;
                    end
                end
                SETTLE: begin
                    if (!seen) begin m_mode = WAIT; m_elapsed = 0; end
                    else begin
                        m_streak++;
                        if (m_streak == ST) begin m_mode = RUN; m_retries = 0; end
                    end
                end
                RUN: begin
                    if (!seen) begin
                        m_mode = PULSE; m_elapsed = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // The model sees the lock input two samples late, like any synchronized
    // consumer would.
    always @(posedge clk) begin
        bit seen;
        if (!reset_n) model_reset();
        else begin
            seen  = pipe1;
            pipe1 = pipe0;
            pipe0 = pll_locked;
            model_step(seen);
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("m_pll_rst", int'(pll_rst), 1);
            check("m_sys_reset_n", int'(sys_reset_n), 0);
            check("m_lock_fail", int'(lock_fail), 0);
            check("m_retry_count", int'(retry_count), 0);
            check("m_lock_loss_count", int'(lock_loss_count), 0);
        end else begin
            check("m_pll_rst", int'(pll_rst), int'(m_mode == PULSE || m_mode == DEAD));
            check("m_sys_reset_n", int'(sys_reset_n), int'(m_mode == RUN));
            check("m_lock_fail", int'(lock_fail), int'(m_failed));
            check("m_retry_count", int'(retry_count), m_retries);
            check("m_lock_loss_count", int'(lock_loss_count), m_losses);
        end
    end

    // ---------------- directed helpers ----------------
    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(pll_rst);
            1:       return int'(sys_reset_n);
            2:       return int'(lock_fail);
            3:       return int'(retry_count);
            default: return int'(lock_loss_count);
        endcase
    endfunction

    // Counts rising edges until the selected output reads target; -1 if the
    // bound expires.
    task automatic wait_for(input int sel, input int target, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sig(sel) == target) begin
                n = i;
                return;
            end
        end
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic apply_reset(input logic lvl);
        @(posedge clk); #1;
        reset_n = 1'b0; restart = 1'b0; pll_locked = lvl;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hold;

        // Lock arrives 10 cycles after release and stays.
        apply_reset(1'b0);
        wait_for(0, 0, 20, n);
        check("rst_pulse_len", n, 4);
        repeat (6) @(posedge clk);
        #1 pll_locked = 1'b1;
        wait_for(1, 1, 100, n);
        check("lock_to_run", n, 10);
        check("run_retry_count", int'(retry_count), 0);

        // Lock lost while running.
        @(posedge clk); #1 pll_locked = 1'b0;
        wait_for(1, 0, 20, n);
        check("drop_to_sysrst", n, 3);
        check("loss_count_one", int'(lock_loss_count), 1);
        wait_for(0, 0, 20, n);
        check("relock_pulse_len", n, 4);

        // Asynchronous reset in the middle of the stable window.
        @(posedge clk); #1 pll_locked = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("loss_kept_in_stable", int'(lock_loss_count), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_pll_rst", int'(pll_rst), 1);
        check("async_sys_reset_n", int'(sys_reset_n), 0);
        check("async_lock_fail", int'(lock_fail), 0);
        check("async_retry", int'(retry_count), 0);
        check("async_loss", int'(lock_loss_count), 0);

        // No lock at all: two timeouts, then FAIL, then restart.
        apply_reset(1'b0);
        wait_for(3, 1, 100, n);
        check("timeout1_at", n, 36);
        check("timeout1_pll_rst", int'(pll_rst), 1);
        wait_for(2, 1, 100, n);
        check("fail_at", n, 36);
        check("fail_retry", int'(retry_count), 2);
        check("fail_pll_rst", int'(pll_rst), 1);
        check("fail_sys_reset_n", int'(sys_reset_n), 0);
        repeat (10) @(negedge clk);
        check("fail_sticky", int'(lock_fail), 1);
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        check("restart_lock_fail", int'(lock_fail), 0);
        check("restart_retry", int'(retry_count), 0);
        check("restart_pll_rst", int'(pll_rst), 1);

        // Lock seen on the last WAIT_LOCK cycle counts as lock.
        apply_reset(1'b0);
        repeat (33) @(posedge clk);
        #1 pll_locked = 1'b1;
        wait_for(1, 1, 100, n);
        check("last_cycle_lock_run", n, 10);

        // One cycle later the timeout has already fired.
        apply_reset(1'b0);
        repeat (34) @(posedge clk);
        #1 pll_locked = 1'b1;
        wait_for(3, 1, 10, n);
        check("late_lock_timeout_at", n, 2);

        // One-cycle glitch during the stable window.
        apply_reset(1'b0);
        repeat (10) @(posedge clk);
        #1 pll_locked = 1'b1;
        repeat (5) @(posedge clk);
        #1 pll_locked = 1'b0;
        @(posedge clk); #1 pll_locked = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch_sys_reset_n", int'(sys_reset_n), 0);
        check("glitch_retry", int'(retry_count), 0);
        check("glitch_pll_rst", int'(pll_rst), 0);
        wait_for(1, 1, 100, n);
        check("glitch_to_run", n, 8);

        // Random lock behaviour with occasional restarts; the model checks it.
        apply_reset(1'b1);
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            restart = 1'b0;
            if (hold == 0) begin
                pll_locked = ($urandom_range(0, 9) < (((c / 500) % 2) ? 3 : 8));
                hold = $urandom_range(0, 60);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 249) == 0) restart = 1'b1;
        end
        @(posedge clk); #1 restart = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 20, number of cycles pll_rst is held high per attempt (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000, maximum cycles in WAIT_LOCK before an attempt fails (min 2).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-locked cycles required before release (min 1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, failed lock attempts allowed before entering FAIL (min 1).
REQ-005 SHALL have port clk, input, 1, single free-running reference clock; all logic in this domain.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1, PLL locked indication, asynchronous to clk.
REQ-008 SHALL have port restart, input, 1, synchronous single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1, active-high reset driven to the PLL.
REQ-010 SHALL have port sys_reset_n, output, 1, active-low reset for logic on PLL output clocks.
REQ-011 SHALL have port lock_fail, output, 1, sticky flag: retries exhausted.
REQ-012 SHALL have port retry_count, output, 2, failed attempts in current sequence, saturating at MAX_RETRIES.
REQ-013 SHALL have port lock_loss_count, output, 8, lock losses seen in RUN, saturating at 255.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer to locked_sync; all decisions use locked_sync only (2-cycle input latency).
REQ-015 SHALL implement states RESET, WAIT_LOCK, STABLE, RUN, FAIL; all outputs registered.
REQ-016 RESET: pll_rst=1, sys_reset_n=0 for exactly RST_PULSE_CYCLES cycles, then WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; locked_sync=1 -> STABLE; after LOCK_TIMEOUT_CYCLES cycles without lock -> retry_count+1, then FAIL if new count equals MAX_RETRIES, else RESET.
REQ-018 Lock and timeout in the same cycle SHALL be treated as lock (go to STABLE, no retry increment).
REQ-019 STABLE: locked_sync high for LOCK_STABLE_CYCLES consecutive cycles -> RUN; any low cycle -> WAIT_LOCK with timeout counter restarted, retry_count unchanged.
REQ-020 RUN: sys_reset_n=1, retry_count cleared on entry; locked_sync low -> RESET, lock_loss_count+1 (saturating), sys_reset_n=0 from the next cycle.
REQ-021 FAIL: pll_rst=1, sys_reset_n=0, lock_fail=1; remains until reset_n or restart.
REQ-022 restart=1 SHALL, from any state, go to RESET next cycle, clear retry_count and lock_fail; lock_loss_count preserved; highest priority after reset_n.
REQ-023 sys_reset_n SHALL be 1 only in RUN; pll_rst SHALL be 1 only in RESET and FAIL.
REQ-024 Counters SHALL be sized with $clog2 of their parameter and SHALL NOT wrap.

Reset
REQ-025 On reset_n low, asynchronously: state=RESET, pll_rst=1, sys_reset_n=0, lock_fail=0, retry_count=0, lock_loss_count=0, synchronizer flops=0, all counters=0.
REQ-026 After reset_n rises, the first RESET pulse SHALL last exactly RST_PULSE_CYCLES cycles.

Structure
REQ-027 Package pll_reset_sequencer_pkg SHALL hold the state enum and counter-width constants (retry_count and lock_loss_count widths).
REQ-028 The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low reset), instantiated once.

Verification (RST_PULSE=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2)
REQ-029 pll_locked rises 10 cycles after reset release and stays -> pll_rst high 4 cycles; sys_reset_n rises exactly 2+8 cycles after lock seen at input; retry_count=0.
REQ-030 pll_locked held 0 -> two 32-cycle timeouts; retry_count 1 then 2; FAIL with lock_fail=1, pll_rst=1; restart pulse -> RESET, lock_fail=0, retry_count=0.
REQ-031 pll_locked glitches low 1 cycle during STABLE -> WAIT_LOCK, no retry increment; RUN reached 8 cycles after stable lock.
REQ-032 pll_locked drops in RUN -> sys_reset_n low 3 cycles later, lock_loss_count=1, new 4-cycle pll_rst pulse.
REQ-033 Lock arriving on the 32nd WAIT_LOCK cycle -> STABLE, retry_count unchanged.
REQ-034 reset_n asserted mid-STABLE -> all outputs at reset values in same cycle, asynchronously.
